// File: rtl/ascon_seq_ctrl.sv
// Sequencer sharing one serial Ascon core between two requesters: round-robin
// grant, core reset, lane load, start/wait with timeout, tag/data drain.
module ascon_seq_ctrl #(
  parameter int unsigned LOAD_LEN = 128,
  parameter int unsigned OUT_LEN  = 128,
  parameter int unsigned TIMEOUT  = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_data0,
  input  logic [11:0] req_data1,
  output logic [1:0]  grant,
  output logic        load_shift,
  output logic        core_rst,
  output logic [11:0] core_lanes,
  output logic        core_enc_start,
  output logic        core_dec_start,
  input  logic        core_enc_ready,
  input  logic        core_dec_ready,
  input  logic        core_auth,
  input  logic        core_ct,
  input  logic        core_tag,
  input  logic        core_pt,
  input  logic        core_dtag,
  output logic        out_valid,
  output logic        out_data,
  output logic        out_tag,
  output logic        done,
  output logic        done_id,
  output logic        auth_ok,
  output logic        timeout
);

  localparam int unsigned CNT_MAX = (LOAD_LEN + 1 > OUT_LEN) ? LOAD_LEN + 1 : OUT_LEN;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_LOAD, S_START, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t        state;
  logic          ptr;
  logic          owner;
  logic          op;
  logic          auth_q;
  logic [CW-1:0] cnt;
  logic [TW-1:0] wcnt;

  // Owner selection and op-dependent muxing of core status/outputs
  logic        pick;
  logic        rdy_match;
  logic        sel_data;
  logic        sel_tag;
  logic [11:0] owner_lanes;

  assign pick        = req[ptr] ? ptr : ~ptr;
  assign rdy_match   = op ? core_dec_ready : core_enc_ready;
  assign sel_data    = op ? core_pt : core_ct;
  assign sel_tag     = op ? core_dtag : core_tag;
  assign owner_lanes = owner ? req_data1 : req_data0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      ptr            <= 1'b0;
      owner          <= 1'b0;
      op             <= 1'b0;
      auth_q         <= 1'b0;
      cnt            <= '0;
      wcnt           <= '0;
      grant          <= 2'b00;
      load_shift     <= 1'b0;
      core_rst       <= 1'b0;
      core_lanes     <= '0;
      core_enc_start <= 1'b0;
      core_dec_start <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= 1'b0;
      out_tag        <= 1'b0;
      done           <= 1'b0;
      done_id        <= 1'b0;
      auth_ok        <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      // Completion and drain outputs are single-cycle unless re-asserted below
      done      <= 1'b0;
      done_id   <= 1'b0;
      auth_ok   <= 1'b0;
      timeout   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_tag   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (|req) begin
            owner    <= pick;
            op       <= req_op[pick];
            grant    <= pick ? 2'b10 : 2'b01;
            core_rst <= 1'b1;
            cnt      <= '0;
            state    <= S_CRST;
          end
        end

        S_CRST: begin
          if (cnt == CW'(1)) begin
            core_rst   <= 1'b0;
            cnt        <= '0;
            load_shift <= 1'b1;
            core_lanes <= owner_lanes;
            state      <= S_LOAD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // LOAD_LEN shift cycles followed by two flush cycles with zero lanes
        S_LOAD: begin
          if (cnt == CW'(LOAD_LEN + 1)) begin
            cnt            <= '0;
            core_enc_start <= ~op;
            core_dec_start <= op;
            state          <= S_START;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt < CW'(LOAD_LEN - 1)) begin
              load_shift <= 1'b1;
              core_lanes <= owner_lanes;
            end else begin
              load_shift <= 1'b0;
              core_lanes <= '0;
            end
          end
        end

        S_START: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (rdy_match) begin
            core_enc_start <= 1'b0;
            core_dec_start <= 1'b0;
            cnt            <= '0;
            state          <= S_DRAIN;
          end else if (wcnt == TW'(TIMEOUT - 1)) begin
            core_enc_start <= 1'b0;
            core_dec_start <= 1'b0;
            grant          <= 2'b00;
            done           <= 1'b1;
            done_id        <= owner;
            timeout        <= 1'b1;
            state          <= S_DONE;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end

        // Cycle 0 is the core's output-register latency; bits are captured
        // from cycle 1 on and presented one cycle later.
        S_DRAIN: begin
          if (cnt == '0) begin
            auth_q <= op & core_auth;
          end else begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_tag   <= sel_tag;
          end
          if (cnt == CW'(OUT_LEN)) begin
            grant   <= 2'b00;
            done    <= 1'b1;
            done_id <= owner;
            auth_ok <= auth_q;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DONE: begin
          ptr   <= ~owner;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// Self-checking bench for ascon_seq_ctrl: behavioural core model feeds a
// scoreboard of expected drain bits; each scenario task checks its own results.
module tb_ascon_seq_ctrl;

  localparam int unsigned LOAD_LEN = 128;
  localparam int unsigned OUT_LEN  = 128;
  localparam int unsigned TIMEOUT  = 4095;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_op = 2'b00;
  logic [11:0] req_data0 = '0;
  logic [11:0] req_data1 = '0;
  logic [1:0]  grant;
  logic        load_shift;
  logic        core_rst;
  logic [11:0] core_lanes;
  logic        core_enc_start;
  logic        core_dec_start;
  logic        core_enc_ready = 1'b0;
  logic        core_dec_ready = 1'b0;
  logic        core_auth = 1'b0;
  logic        core_ct = 1'b0;
  logic        core_tag = 1'b0;
  logic        core_pt = 1'b0;
  logic        core_dtag = 1'b0;
  logic        out_valid;
  logic        out_data;
  logic        out_tag;
  logic        done;
  logic        done_id;
  logic        auth_ok;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  ascon_seq_ctrl #(.LOAD_LEN(LOAD_LEN), .OUT_LEN(OUT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op),
    .req_data0(req_data0), .req_data1(req_data1),
    .grant(grant), .load_shift(load_shift), .core_rst(core_rst), .core_lanes(core_lanes),
    .core_enc_start(core_enc_start), .core_dec_start(core_dec_start),
    .core_enc_ready(core_enc_ready), .core_dec_ready(core_dec_ready), .core_auth(core_auth),
    .core_ct(core_ct), .core_tag(core_tag), .core_pt(core_pt), .core_dtag(core_dtag),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .done(done), .done_id(done_id), .auth_ok(auth_ok), .timeout(timeout)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one job for requester id end to end with a behavioural core.
  // ready_delay < 0 means the core never reports ready.
  task automatic do_job(input string name, input int id, input logic jop, input logic auth,
                        input int ready_delay, input bit wrong_pulse, input bit drop_mid,
                        input int abort_beat, output int gap);
    logic [11:0] lanes;
    logic [1:0]  exp_grant;
    logic [1:0]  exp;
    logic [OUT_LEN-1:0] d_vec, t_vec;
    int crst_n = 0, loads = 0, lanes_bad = 0, starts = 0, wrong = 0;
    int beats = 0, beat_bad = 0, grant_bad = 0, phase = 0, idx = 0, cyc = 0;
    int exp_starts, exp_beats;
    bit done_seen = 0, aborted = 0;
    logic got_id, got_auth, got_to, got_start;
    logic [1:0] got_grant;

    for (int i = 0; i < int'(OUT_LEN); i++) begin
      d_vec[i] = 1'($urandom);
      t_vec[i] = 1'($urandom);
    end
    lanes      = (id == 1) ? req_data1 : req_data0;
    exp_grant  = (id == 1) ? 2'b10 : 2'b01;
    exp_starts = (ready_delay >= 0) ? ready_delay + 1 : int'(TIMEOUT) + 1;
    exp_beats  = (ready_delay >= 0) ? int'(OUT_LEN) : 0;
    core_auth  = auth;
    got_id = 0; got_auth = 0; got_to = 0; got_start = 0; got_grant = 0;

    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (grant === 2'b00 && gap < 20);
    checks++;
    if (grant !== exp_grant) begin
      errors++;
      $display("FAIL %s grant: got %b want %b", name, grant, exp_grant);
    end

    while (!done_seen && !aborted && cyc < 6000) begin
      cyc++;
      if (core_rst === 1'b1) crst_n++;
      if (load_shift === 1'b1) begin
        loads++;
        if (core_lanes !== lanes) lanes_bad++;
      end else if (core_lanes !== 12'h000) lanes_bad++;
      if ((jop ? core_enc_start : core_dec_start) !== 1'b0) wrong++;
      if ((jop ? core_dec_start : core_enc_start) === 1'b1) starts++;
      if (out_valid === 1'b1) begin
        beats++;
        if (exp_q.size() == 0) beat_bad++;
        else begin
          exp = exp_q.pop_front();
          if ({out_data, out_tag} !== exp) beat_bad++;
        end
      end
      if (done === 1'b1) begin
        done_seen = 1;
        got_id = done_id; got_auth = auth_ok; got_to = timeout;
        got_start = core_enc_start | core_dec_start;
        got_grant = grant;
      end else if (grant !== exp_grant) grant_bad++;

      if (abort_beat >= 0 && beats == abort_beat && !done_seen) begin
        rst = 1'b0;
        #1;
        checks++;
        if ({grant, load_shift, core_rst, core_lanes, core_enc_start, core_dec_start,
             out_valid, out_data, out_tag, done, done_id, auth_ok, timeout} !== '0) begin
          errors++;
          $display("FAIL %s abort_outputs: got grant=%b valid=%b lanes=%h want all 0",
                   name, grant, out_valid, core_lanes);
        end
        aborted = 1;
      end
      if (drop_mid && loads == 10) req[id] = 1'b0;

      if (!done_seen && !aborted) begin
        @(posedge clk);
        #1;
        core_enc_ready = 1'b0;
        core_dec_ready = 1'b0;
        if (phase == 1) begin
          {core_ct, core_tag, core_pt, core_dtag} = 4'($urandom);
          phase = 2;
        end else if (phase == 2) begin
          if (idx < int'(OUT_LEN)) begin
            core_ct   = jop ? 1'($urandom) : d_vec[idx];
            core_tag  = jop ? 1'($urandom) : t_vec[idx];
            core_pt   = jop ? d_vec[idx] : 1'($urandom);
            core_dtag = jop ? t_vec[idx] : 1'($urandom);
            exp_q.push_back({d_vec[idx], t_vec[idx]});
            idx++;
          end else begin
            {core_ct, core_tag, core_pt, core_dtag} = 4'($urandom);
          end
        end else begin
          if (wrong_pulse && starts == 20) begin
            if (jop) core_enc_ready = 1'b1;
            else core_dec_ready = 1'b1;
          end
          if (ready_delay >= 0 && starts == ready_delay) begin
            if (jop) core_dec_ready = 1'b1;
            else core_enc_ready = 1'b1;
            phase = 1;
          end
        end
        @(negedge clk);
      end
    end

    core_enc_ready = 0; core_dec_ready = 0;
    {core_ct, core_tag, core_pt, core_dtag} = 4'b0000;
    if (aborted) begin
      exp_q.delete();
      return;
    end
    req[id] = 1'b0;

    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s done_seen: got none within %0d cycles want done", name, cyc);
      exp_q.delete();
      return;
    end
    checks++;
    if (got_id !== 1'(id)) begin
      errors++; $display("FAIL %s done_id: got %b want %0d", name, got_id, id);
    end
    checks++;
    if (got_auth !== (jop & auth & (ready_delay >= 0))) begin
      errors++; $display("FAIL %s auth_ok: got %b want %b", name, got_auth,
                         jop & auth & (ready_delay >= 0));
    end
    checks++;
    if (got_to !== (ready_delay < 0)) begin
      errors++; $display("FAIL %s timeout: got %b want %b", name, got_to, ready_delay < 0);
    end
    checks++;
    if (crst_n != 2) begin
      errors++; $display("FAIL %s core_rst_cycles: got %0d want 2", name, crst_n);
    end
    checks++;
    if (loads != int'(LOAD_LEN) || lanes_bad != 0) begin
      errors++; $display("FAIL %s load: got %0d shifts %0d bad lanes want %0d shifts 0 bad",
                         name, loads, lanes_bad, LOAD_LEN);
    end
    checks++;
    if (starts != exp_starts || wrong != 0) begin
      errors++; $display("FAIL %s start_cycles: got %0d (wrong %0d) want %0d (wrong 0)",
                         name, starts, wrong, exp_starts);
    end
    checks++;
    if (beats != exp_beats || beat_bad != 0) begin
      errors++; $display("FAIL %s drain: got %0d beats %0d bad want %0d beats 0 bad",
                         name, beats, beat_bad, exp_beats);
    end
    checks++;
    if (got_grant !== 2'b00 || grant_bad != 0 || got_start !== 1'b0) begin
      errors++; $display("FAIL %s at_done: got grant=%b start=%b grant_bad=%0d want 00 0 0",
                         name, got_grant, got_start, grant_bad);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s leftover: got %0d queued want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, load_shift, core_rst, core_lanes, core_enc_start, core_dec_start,
         out_valid, out_data, out_tag, done, done_id, auth_ok, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b core_rst=%b lanes=%h want all 0",
               grant, core_rst, core_lanes);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== 2'b00 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got grant=%b core_rst=%b want 00 0", grant, core_rst);
    end
  endtask

  task automatic test_encrypt();
    int gap;
    req_data0 = 12'($urandom); req_data1 = 12'($urandom);
    req_op = 2'b00;
    req = 2'b01;
    do_job("enc", 0, 1'b0, 1'b1, 200, 0, 0, -1, gap);
  endtask

  task automatic test_back_to_back();
    int gap;
    req_data0 = 12'h5a3; req_data1 = 12'hc3c;
    req_op = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 2'b11;
    do_job("rr0", 0, 1'b0, 1'b0, 30, 0, 0, -1, gap);
    do_job("rr1", 1, 1'b1, 1'b1, 25, 0, 0, -1, gap);
    checks++;
    if (gap != 2) begin
      errors++; $display("FAIL rr_gap: got %0d negedges to grant want 2", gap);
    end
    req_op = 2'b00;
    req = 2'b11;
    do_job("rr2", 0, 1'b0, 1'b0, 10, 0, 0, -1, gap);
    do_job("rr3", 1, 1'b0, 1'b0, 10, 0, 0, -1, gap);
  endtask

  task automatic test_decrypt();
    int gap;
    req_data1 = 12'($urandom);
    req_op = 2'b10;
    repeat (2) @(negedge clk);
    req = 2'b10;
    do_job("dec_auth1", 1, 1'b1, 1'b1, 40, 0, 0, -1, gap);
    req = 2'b10;
    do_job("dec_auth0", 1, 1'b1, 1'b0, 40, 0, 1, -1, gap);
  endtask

  task automatic test_timeout();
    int gap;
    req_op = 2'b00;
    repeat (2) @(negedge clk);
    req = 2'b01;
    do_job("timeout", 0, 1'b0, 1'b1, -1, 0, 0, -1, gap);
  endtask

  task automatic test_abort();
    int gap;
    req_op = 2'b10;
    req_data1 = 12'($urandom);
    repeat (2) @(negedge clk);
    req = 2'b10;
    do_job("abort", 1, 1'b1, 1'b1, 20, 0, 0, 50, gap);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || grant !== 2'b00 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_held: got done=%b grant=%b valid=%b want 0 00 0",
                         done, grant, out_valid);
    end
    rst = 1'b1;
    do_job("restart", 1, 1'b1, 1'b1, 20, 0, 0, -1, gap);
  endtask

  task automatic test_wrong_ready();
    int gap;
    req_op = 2'b00;
    req_data0 = 12'($urandom);
    repeat (2) @(negedge clk);
    req = 2'b01;
    do_job("wrong_ready", 0, 1'b0, 1'b0, 60, 1, 0, -1, gap);
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_back_to_back();
    test_decrypt();
    test_timeout();
    test_abort();
    test_wrong_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
